// File: rtl/moving_average_window_stats_if.sv
// Sample/result bundle between the moving-average filter, the window-statistics
// block and its consumer. The master drives samples and control; the slave reports results.
interface moving_average_window_stats_if #(
  parameter int DATA_W = 10,
  parameter int WCNT_W = 8
);
  logic              ena;
  logic [DATA_W-1:0] data_in;
  logic              strobe_in;
  logic [1:0]        win_select;
  logic              clear;
  logic [DATA_W-1:0] min_out;
  logic [DATA_W-1:0] max_out;
  logic [DATA_W-1:0] span_out;
  logic              result_strobe;
  logic [WCNT_W-1:0] window_count;

  modport master (
    output ena, data_in, strobe_in, win_select, clear,
    input  min_out, max_out, span_out, result_strobe, window_count
  );

  modport slave (
    input  ena, data_in, strobe_in, win_select, clear,
    output min_out, max_out, span_out, result_strobe, window_count
  );
endinterface

// File: rtl/moving_average_window_stats.sv
// Groups strobed samples into windows of 2^(WIN_LOG2+win_select) samples and reports
// min, max and span of each completed window with a one-cycle result strobe.
module moving_average_window_stats #(
  parameter int DATA_W   = 10,
  parameter int WIN_LOG2 = 4,
  parameter int WCNT_W   = 8
) (
  input logic clk,
  input logic rst_n,
  moving_average_window_stats_if.slave bus
);

  // Wide enough to hold the largest window length, 2^(WIN_LOG2+3).
  localparam int CNT_W = WIN_LOG2 + 4;

  typedef enum logic {
    IDLE,
    ACCUM
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        win_q, win_d;
  logic              strobe_prev_q;
  logic [DATA_W-1:0] cur_min_q, cur_min_d;
  logic [DATA_W-1:0] cur_max_q, cur_max_d;
  logic [DATA_W-1:0] min_q, min_d;
  logic [DATA_W-1:0] max_q, max_d;
  logic [DATA_W-1:0] span_q, span_d;
  logic              res_q, res_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;

  logic              accept;
  logic [1:0]        sel;
  logic [CNT_W-1:0]  win_len;
  logic              done;
  logic [DATA_W-1:0] fin_min, fin_max;

  // A held strobe is one sample: only its rising edge counts.
  assign accept  = bus.ena & bus.strobe_in & ~strobe_prev_q;
  // A new window takes its size from the live select; a running one keeps its latched size.
  assign sel     = (state_q == IDLE) ? bus.win_select : win_q;
  assign win_len = CNT_W'(1) << (WIN_LOG2 + int'(sel));

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path leaves one
    // unassigned and no latch is inferred.
    state_d   = state_q;
    cnt_d     = cnt_q;
    win_d     = win_q;
    cur_min_d = cur_min_q;
    cur_max_d = cur_max_q;
    min_d     = min_q;
    max_d     = max_q;
    span_d    = span_q;
    wcnt_d    = wcnt_q;
    res_d     = 1'b0;
    done      = 1'b0;
    fin_min   = cur_min_q;
    fin_max   = cur_max_q;

    // Clear aborts the partial window and swallows any sample arriving with it.
    if (bus.ena && bus.clear) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (accept) begin
      unique case (state_q)
        IDLE: begin
          cur_min_d = bus.data_in;
          cur_max_d = bus.data_in;
          win_d     = bus.win_select;
          cnt_d     = CNT_W'(1);
          state_d   = ACCUM;
          fin_min   = bus.data_in;
          fin_max   = bus.data_in;
          done      = (win_len == CNT_W'(1));
        end
        ACCUM: begin
          fin_min   = (bus.data_in < cur_min_q) ? bus.data_in : cur_min_q;
          fin_max   = (bus.data_in > cur_max_q) ? bus.data_in : cur_max_q;
          cur_min_d = fin_min;
          cur_max_d = fin_max;
          cnt_d     = cnt_q + CNT_W'(1);
          done      = (cnt_q == win_len - CNT_W'(1));
        end
        default: state_d = IDLE;
      endcase

      if (done) begin
        min_d   = fin_min;
        max_d   = fin_max;
        span_d  = fin_max - fin_min;
        wcnt_d  = wcnt_q + WCNT_W'(1);
        res_d   = 1'b1;
        cnt_d   = '0;
        state_d = IDLE;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values, independent of the order the simulator evaluates blocks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      win_q         <= '0;
      strobe_prev_q <= 1'b0;
      cur_min_q     <= '0;
      cur_max_q     <= '0;
      min_q         <= '0;
      max_q         <= '0;
      span_q        <= '0;
      res_q         <= 1'b0;
      wcnt_q        <= '0;
    end else begin
      // Edge history tracks the strobe even while disabled.
      strobe_prev_q <= bus.strobe_in;
      if (bus.ena) begin
        state_q   <= state_d;
        cnt_q     <= cnt_d;
        win_q     <= win_d;
        cur_min_q <= cur_min_d;
        cur_max_q <= cur_max_d;
        min_q     <= min_d;
        max_q     <= max_d;
        span_q    <= span_d;
        wcnt_q    <= wcnt_d;
      end
      res_q <= res_d;
    end
  end

  assign bus.min_out       = min_q;
  assign bus.max_out       = max_q;
  assign bus.span_out      = span_q;
  assign bus.result_strobe = res_q;
  assign bus.window_count  = wcnt_q;

endmodule

// File: tb/tb_moving_average_window_stats.sv
// Randomised and directed bench for moving_average_window_stats against a
// queue-based window model.
module tb_moving_average_window_stats;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  moving_average_window_stats_if #(.DATA_W(10), .WCNT_W(8)) bus ();

  moving_average_window_stats #(
    .DATA_W(10),
    .WIN_LOG2(4),
    .WCNT_W(8)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  int total = 0;
  int bad   = 0;
  int n_results = 0;

  // Reference model: samples of the open window, its length, and the last results.
  int q[$];
  int exp_len    = 16;
  int exp_min    = 0;
  int exp_max    = 0;
  int exp_span   = 0;
  int exp_count  = 0;
  bit exp_strobe = 1'b0;
  bit last_strobe = 1'b0;

  task automatic model_reset();
    q.delete();
    exp_min = 0; exp_max = 0; exp_span = 0; exp_count = 0;
    exp_strobe = 1'b0;
  endtask

  task automatic model_accept(input int d, input int ws);
    int mn, mx;
    if (q.size() == 0) exp_len = 16 << ws;
    q.push_back(d);
    if (q.size() == exp_len) begin
      mn = 1 << 30; mx = -1;
      foreach (q[i]) begin
        if (q[i] < mn) mn = q[i];
        if (q[i] > mx) mx = q[i];
      end
      exp_min = mn; exp_max = mx; exp_span = mx - mn;
      exp_count = (exp_count + 1) % 256;
      exp_strobe = 1'b1;
      q.delete();
    end
  endtask

  // Drives one strobe held for `hold` cycles, then one idle cycle, checking every cycle.
  task automatic send_sample(input int d, input int hold, input bit en, input bit clr);
    bit acc;
    @(negedge clk);
    bus.data_in   = 10'(d);
    bus.strobe_in = 1'b1;
    bus.ena       = en;
    bus.clear     = clr;
    @(posedge clk); #1;
    acc = en && !last_strobe;
    exp_strobe = 1'b0;
    if (en && clr) q.delete();
    else if (acc) model_accept(d, int'(bus.win_select));
    last_strobe = 1'b1;
    total++;
    if (bus.result_strobe !== exp_strobe) begin
      bad++; $display("FAIL strobe_edge: got %0b want %0b", bus.result_strobe, exp_strobe);
    end
    total++;
    if (bus.min_out !== 10'(exp_min) || bus.max_out !== 10'(exp_max) ||
        bus.span_out !== 10'(exp_span) || bus.window_count !== 8'(exp_count)) begin
      bad++;
      $display("FAIL results: got min=%0d max=%0d span=%0d cnt=%0d want %0d %0d %0d %0d",
               bus.min_out, bus.max_out, bus.span_out, bus.window_count,
               exp_min, exp_max, exp_span, exp_count);
    end
    if (bus.result_strobe === 1'b1) n_results++;
    for (int h = 1; h < hold; h++) begin
      @(negedge clk);
      bus.clear = 1'b0;
      @(posedge clk); #1;
      total++;
      if (bus.result_strobe !== 1'b0) begin
        bad++; $display("FAIL strobe_hold: got %0b want 0", bus.result_strobe);
      end
    end
    @(negedge clk);
    bus.strobe_in = 1'b0;
    bus.clear     = 1'b0;
    bus.ena       = 1'b1;
    @(posedge clk); #1;
    last_strobe = 1'b0;
    total++;
    if (bus.result_strobe !== 1'b0) begin
      bad++; $display("FAIL strobe_pulse: got %0b want 0", bus.result_strobe);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    total++;
    if (bus.min_out !== '0 || bus.max_out !== '0 || bus.span_out !== '0 ||
        bus.result_strobe !== 1'b0 || bus.window_count !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got min=%0d max=%0d span=%0d strb=%0b cnt=%0d want all 0",
               bus.min_out, bus.max_out, bus.span_out, bus.result_strobe, bus.window_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    bus.ena = 1'b1; bus.data_in = '0; bus.strobe_in = 1'b0;
    bus.win_select = 2'd0; bus.clear = 1'b0;
    repeat (2) @(posedge clk);
    do_reset();
  endtask

  task automatic test_ramp();
    int r0 = n_results;
    bus.win_select = 2'd0;
    for (int i = 0; i < 16; i++) send_sample(i, 1, 1'b1, 1'b0);
    total++;
    if (n_results - r0 != 1 || bus.min_out !== 10'd0 || bus.max_out !== 10'd15 ||
        bus.span_out !== 10'd15 || bus.window_count !== 8'd1) begin
      bad++;
      $display("FAIL ramp: results=%0d min=%0d max=%0d span=%0d cnt=%0d want 1 0 15 15 1",
               n_results - r0, bus.min_out, bus.max_out, bus.span_out, bus.window_count);
    end
  endtask

  task automatic test_const();
    int r0 = n_results;
    bus.win_select = 2'd1;
    for (int i = 0; i < 16; i++) send_sample(512, 1, 1'b1, 1'b0);
    total++;
    if (n_results != r0) begin
      bad++; $display("FAIL const_half: results=%0d want 0", n_results - r0);
    end
    for (int i = 0; i < 16; i++) send_sample(512, 1, 1'b1, 1'b0);
    total++;
    if (n_results - r0 != 1 || bus.min_out !== 10'd512 || bus.max_out !== 10'd512 ||
        bus.span_out !== 10'd0) begin
      bad++;
      $display("FAIL const: results=%0d min=%0d max=%0d span=%0d want 1 512 512 0",
               n_results - r0, bus.min_out, bus.max_out, bus.span_out);
    end
  endtask

  task automatic test_midwin_select();
    int r0 = n_results;
    bus.win_select = 2'd0;
    for (int i = 0; i < 5; i++) send_sample($urandom_range(1023), 1, 1'b1, 1'b0);
    bus.win_select = 2'd3;
    for (int i = 0; i < 11; i++) send_sample($urandom_range(1023), 1, 1'b1, 1'b0);
    total++;
    if (n_results - r0 != 1) begin
      bad++; $display("FAIL midwin_16: results=%0d want 1", n_results - r0);
    end
    for (int i = 0; i < 127; i++) send_sample($urandom_range(1023), 1, 1'b1, 1'b0);
    total++;
    if (n_results - r0 != 1) begin
      bad++; $display("FAIL midwin_127: results=%0d want 1", n_results - r0);
    end
    send_sample($urandom_range(1023), 1, 1'b1, 1'b0);
    total++;
    if (n_results - r0 != 2) begin
      bad++; $display("FAIL midwin_128: results=%0d want 2", n_results - r0);
    end
  endtask

  task automatic test_clear();
    int r0 = n_results;
    bus.win_select = 2'd0;
    for (int i = 0; i < 10; i++) send_sample(i * 90, 1, 1'b1, 1'b0);
    send_sample(5, 1, 1'b1, 1'b1);
    for (int i = 0; i < 16; i++) send_sample(100 + i, 1, 1'b1, 1'b0);
    total++;
    if (n_results - r0 != 1 || bus.min_out !== 10'd100 || bus.max_out !== 10'd115) begin
      bad++;
      $display("FAIL clear: results=%0d min=%0d max=%0d want 1 100 115",
               n_results - r0, bus.min_out, bus.max_out);
    end
  endtask

  task automatic test_hold_and_ena();
    int r0 = n_results;
    bus.win_select = 2'd0;
    for (int i = 0; i < 16; i++) begin
      send_sample((i % 2) ? 1023 : 0, 5, 1'b1, 1'b0);
      if (i % 4 == 1) send_sample(500, 2, 1'b0, 1'b0);
    end
    total++;
    if (n_results - r0 != 1 || bus.span_out !== 10'd1023) begin
      bad++;
      $display("FAIL hold: results=%0d span=%0d want 1 1023", n_results - r0, bus.span_out);
    end
  endtask

  task automatic test_reset_mid();
    bus.win_select = 2'd0;
    for (int i = 0; i < 7; i++) send_sample($urandom_range(1023), 1, 1'b1, 1'b0);
    do_reset();
    for (int i = 0; i < 16; i++) send_sample(200 + i, 1, 1'b1, 1'b0);
    total++;
    if (bus.window_count !== 8'd1 || bus.min_out !== 10'd200 || bus.max_out !== 10'd215) begin
      bad++;
      $display("FAIL reset_mid: cnt=%0d min=%0d max=%0d want 1 200 215",
               bus.window_count, bus.min_out, bus.max_out);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      bus.win_select = 2'($urandom_range(3));
      send_sample($urandom_range(1023), $urandom_range(1, 3),
                  ($urandom_range(9) != 0), ($urandom_range(29) == 0));
    end
  endtask

  task automatic test_wrap();
    do_reset();
    bus.win_select = 2'd0;
    for (int w = 0; w < 256; w++)
      for (int i = 0; i < 16; i++) send_sample($urandom_range(1023), 1, 1'b1, 1'b0);
    total++;
    if (bus.window_count !== 8'd0) begin
      bad++; $display("FAIL wrap: cnt=%0d want 0", bus.window_count);
    end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_const();
    test_midwin_select();
    test_clear();
    test_hold_and_ena();
    test_random();
    test_reset_mid();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
